// File: rtl/tpum_xbox_arb_if.sv
// Crossbar-side beat handshake of the TPUM xbox arbiter.
// The master side drives beat requests; the slave side returns the beat accept.
interface tpum_xbox_arb_if #(
  parameter int LEN_W = 4
);
  logic             xbox_req;
  logic             xbox_write;
  logic             xbox_ack;
  logic [LEN_W-1:0] beat_cnt;
  logic             last;

  modport master (
    output xbox_req,
    output xbox_write,
    output beat_cnt,
    output last,
    input  xbox_ack
  );

  modport slave (
    input  xbox_req,
    input  xbox_write,
    input  beat_cnt,
    input  last,
    output xbox_ack
  );
endinterface

// File: rtl/tpum_xbox_arb.sv
// Round-robin arbiter and burst sequencer for the shared TPUM xbox port.
// Serves R1 loader, R2 loader and write-back one burst at a time.
module tpum_xbox_arb #(
  parameter int NREQ  = 3,
  parameter int LEN_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  input  logic [NREQ-1:0]       req_write,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [NREQ-1:0]       done,
  tpum_xbox_arb_if.master       xb
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    win, win_n;
  logic [IW-1:0]    pick;
  logic             found;
  logic [LEN_W-1:0] len, len_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [NREQ-1:0]  gnt_n;
  logic             busy_n;
  logic             xreq_n;
  logic             xwr_n;
  logic             last;
  int               j;

  // Scan ptr, ptr+1, ... wrapping, first active request wins
  always_comb begin
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  assign last        = (state == XFER) && (cnt == len);
  assign done        = gnt & {NREQ{xb.xbox_ack & last}};
  assign xb.beat_cnt = cnt;
  assign xb.last     = last;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    len_n   = len;
    cnt_n   = cnt;
    gnt_n   = gnt;
    busy_n  = busy;
    xreq_n  = xb.xbox_req;
    xwr_n   = xb.xbox_write;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n = XFER;
          win_n   = pick;
          len_n   = req_len[pick*LEN_W +: LEN_W];
          cnt_n   = '0;
          gnt_n   = NREQ'(1) << pick;
          busy_n  = 1'b1;
          xreq_n  = 1'b1;
          xwr_n   = req_write[pick];
        end
      end
      XFER: begin
        if (xb.xbox_ack) begin
          if (last) begin
            state_n = IDLE;
            ptr_n   = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
            cnt_n   = '0;
            gnt_n   = '0;
            busy_n  = 1'b0;
            xreq_n  = 1'b0;
            xwr_n   = 1'b0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      win           <= '0;
      len           <= '0;
      cnt           <= '0;
      gnt           <= '0;
      busy          <= 1'b0;
      xb.xbox_req   <= 1'b0;
      xb.xbox_write <= 1'b0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      win           <= win_n;
      len           <= len_n;
      cnt           <= cnt_n;
      gnt           <= gnt_n;
      busy          <= busy_n;
      xb.xbox_req   <= xreq_n;
      xb.xbox_write <= xwr_n;
    end
  end

endmodule

// File: tb/tb_tpum_xbox_arb.sv
// Directed bench for tpum_xbox_arb: cycle vector table plus a max-length burst.
// Inputs change just after each rising edge; outputs are checked on the falling edge.
module tb_tpum_xbox_arb;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [11:0] req_len;
  logic [2:0]  req_write;
  logic [2:0]  gnt;
  logic        busy;
  logic [2:0]  done;
  int          checks;
  int          errors;

  tpum_xbox_arb_if #(.LEN_W(4)) xb ();

  tpum_xbox_arb #(.NREQ(3), .LEN_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_len   (req_len),
    .req_write (req_write),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .xb        (xb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic [2:0]  rq;
    logic [11:0] ln;
    logic [2:0]  wr;
    logic        ack;
    logic [2:0]  g;
    logic        act;
    logic        xw;
    logic [3:0]  b;
    logic        l;
    logic [2:0]  d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rn, logic [2:0] rq, logic [11:0] ln,
                             logic [2:0] wr, logic ack, logic [2:0] g,
                             logic act, logic xw, logic [3:0] b,
                             logic l, logic [2:0] d);
    vec_t t;
    t.rn = rn; t.rq = rq; t.ln = ln; t.wr = wr; t.ack = ack;
    t.g = g; t.act = act; t.xw = xw; t.b = b; t.l = l; t.d = d;
    return t;
  endfunction

  function automatic vec_t vi(logic rn, logic [2:0] rq, logic [11:0] ln,
                              logic [2:0] wr, logic ack);
    return v(rn, rq, ln, wr, ack, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000);
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", nm, k, act, exp);
    end
  endtask

  task automatic chk_all(int k, logic [2:0] g, logic a, logic xw,
                         logic [3:0] b, logic l, logic [2:0] d);
    chk("gnt", k, 32'(gnt), 32'(g));
    chk("busy", k, 32'(busy), 32'(a));
    chk("xbox_req", k, 32'(xb.xbox_req), 32'(a));
    chk("xbox_write", k, 32'(xb.xbox_write), 32'(xw));
    chk("beat_cnt", k, 32'(xb.beat_cnt), 32'(b));
    chk("last", k, 32'(xb.last), 32'(l));
    chk("done", k, 32'(done), 32'(d));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req = '0;
    req_len = '0;
    req_write = '0;
    xb.xbox_ack = 1'b0;

    // single request, one beat
    tbl.push_back(vi(1, 3'b001, 12'h000, 3'b000, 1));
    tbl.push_back(v (1, 3'b001, 12'h000, 3'b000, 1, 3'b001, 1, 0, 0, 1, 3'b001));
    tbl.push_back(vi(1, 3'b000, 12'h000, 3'b000, 1));
    // reset, then three simultaneous 2-beat bursts
    tbl.push_back(vi(0, 3'b000, 12'h000, 3'b000, 1));
    tbl.push_back(vi(1, 3'b111, 12'h111, 3'b000, 1));
    tbl.push_back(v (1, 3'b111, 12'h111, 3'b000, 1, 3'b001, 1, 0, 0, 0, 3'b000));
    tbl.push_back(v (1, 3'b111, 12'h111, 3'b000, 1, 3'b001, 1, 0, 1, 1, 3'b001));
    tbl.push_back(vi(1, 3'b110, 12'h111, 3'b000, 1));
    tbl.push_back(v (1, 3'b110, 12'h111, 3'b000, 1, 3'b010, 1, 0, 0, 0, 3'b000));
    tbl.push_back(v (1, 3'b110, 12'h111, 3'b000, 1, 3'b010, 1, 0, 1, 1, 3'b010));
    tbl.push_back(vi(1, 3'b100, 12'h111, 3'b000, 1));
    tbl.push_back(v (1, 3'b100, 12'h111, 3'b000, 1, 3'b100, 1, 0, 0, 0, 3'b000));
    tbl.push_back(v (1, 3'b100, 12'h111, 3'b000, 1, 3'b100, 1, 0, 1, 1, 3'b100));
    tbl.push_back(vi(1, 3'b000, 12'h000, 3'b000, 1));
    // backpressure on requester 1, len 3, inputs disturbed mid-burst
    tbl.push_back(vi(1, 3'b010, 12'h030, 3'b000, 0));
    tbl.push_back(v (1, 3'b010, 12'h030, 3'b000, 1, 3'b010, 1, 0, 0, 0, 3'b000));
    tbl.push_back(v (1, 3'b111, 12'h000, 3'b111, 0, 3'b010, 1, 0, 1, 0, 3'b000));
    tbl.push_back(v (1, 3'b111, 12'h000, 3'b111, 0, 3'b010, 1, 0, 1, 0, 3'b000));
    tbl.push_back(v (1, 3'b010, 12'h030, 3'b000, 1, 3'b010, 1, 0, 1, 0, 3'b000));
    tbl.push_back(v (1, 3'b010, 12'h030, 3'b000, 1, 3'b010, 1, 0, 2, 0, 3'b000));
    tbl.push_back(v (1, 3'b010, 12'h030, 3'b000, 0, 3'b010, 1, 0, 3, 1, 3'b000));
    tbl.push_back(v (1, 3'b010, 12'h030, 3'b000, 1, 3'b010, 1, 0, 3, 1, 3'b010));
    tbl.push_back(vi(1, 3'b000, 12'h000, 3'b000, 1));
    // fairness: 0 and 2 re-requesting, ptr starts at 2
    tbl.push_back(vi(1, 3'b101, 12'h000, 3'b100, 1));
    tbl.push_back(v (1, 3'b101, 12'h000, 3'b100, 1, 3'b100, 1, 1, 0, 1, 3'b100));
    tbl.push_back(vi(1, 3'b101, 12'h000, 3'b100, 1));
    tbl.push_back(v (1, 3'b101, 12'h000, 3'b100, 1, 3'b001, 1, 0, 0, 1, 3'b001));
    tbl.push_back(vi(1, 3'b101, 12'h000, 3'b100, 1));
    tbl.push_back(v (1, 3'b101, 12'h000, 3'b100, 1, 3'b100, 1, 1, 0, 1, 3'b100));
    tbl.push_back(vi(1, 3'b101, 12'h000, 3'b100, 1));
    tbl.push_back(v (1, 3'b101, 12'h000, 3'b100, 1, 3'b001, 1, 0, 0, 1, 3'b001));
    tbl.push_back(vi(1, 3'b000, 12'h000, 3'b000, 1));
    // reset during beat 2 of a 4-beat burst, then re-arbitration
    tbl.push_back(vi(1, 3'b100, 12'h300, 3'b000, 1));
    tbl.push_back(v (1, 3'b100, 12'h300, 3'b000, 1, 3'b100, 1, 0, 0, 0, 3'b000));
    tbl.push_back(v (1, 3'b100, 12'h300, 3'b000, 1, 3'b100, 1, 0, 1, 0, 3'b000));
    tbl.push_back(vi(0, 3'b100, 12'h300, 3'b000, 1));
    tbl.push_back(vi(1, 3'b100, 12'h300, 3'b000, 1));
    tbl.push_back(v (1, 3'b100, 12'h300, 3'b000, 1, 3'b100, 1, 0, 0, 0, 3'b000));
    tbl.push_back(v (1, 3'b100, 12'h300, 3'b000, 1, 3'b100, 1, 0, 1, 0, 3'b000));
    tbl.push_back(v (1, 3'b100, 12'h300, 3'b000, 1, 3'b100, 1, 0, 2, 0, 3'b000));
    tbl.push_back(v (1, 3'b100, 12'h300, 3'b000, 1, 3'b100, 1, 0, 3, 1, 3'b100));
    tbl.push_back(vi(1, 3'b000, 12'h000, 3'b000, 1));

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all(-1, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000);

    foreach (tbl[k]) begin
      @(posedge clk);
      #1;
      rst_n       = tbl[k].rn;
      req         = tbl[k].rq;
      req_len     = tbl[k].ln;
      req_write   = tbl[k].wr;
      xb.xbox_ack = tbl[k].ack;
      @(negedge clk);
      chk_all(k, tbl[k].g, tbl[k].act, tbl[k].xw, tbl[k].b, tbl[k].l, tbl[k].d);
    end

    // maximum length write burst on requester 0
    @(posedge clk);
    #1;
    req         = 3'b001;
    req_len     = 12'h00f;
    req_write   = 3'b001;
    xb.xbox_ack = 1'b1;
    @(negedge clk);
    chk_all(100, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      chk_all(101 + i, 3'b001, 1'b1, 1'b1, 4'(i), (i == 15),
              (i == 15) ? 3'b001 : 3'b000);
    end
    @(posedge clk);
    #1;
    req = 3'b000;
    @(negedge clk);
    chk_all(117, 3'b000, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
